// File: rtl/glyph_prefetch_ctrl.sv
// Prefetches the eight glyph rows of one score line during horizontal blanking and publishes them at DrawX == 0.
// Optional build macro LEAD_ZERO_BLANK_EN blanks the tens slot when the tens digit is zero.
module glyph_prefetch_ctrl #(
  parameter int TOP_Y        = 164,
  parameter int GLYPH_H      = 15,
  parameter int NUM_LINES    = 10,
  parameter int TRIG_X       = 640,
  parameter int GLYPH_STRIDE = 16,
  parameter int ROM_BASE     = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [9:0][15:0] floatingpoint,
  output logic [15:0]      rom_addr,
  input  logic [15:0]      rom_q,
  output logic [7:0][15:0] char_row,
  output logic             row_valid,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [3:0]       r_line;
  logic [7:0]       r_row;
  logic [15:0]      r_snap;
  logic [7:0][15:0] r_shadow;
  logic             r_pending;

  logic [10:0] w_ny;
  logic [10:0] w_off;
  logic        w_in_region;
  logic        w_trig;
  logic [3:0]  w_line;
  logic [7:0]  w_row;
  logic [2:0]  w_next_k;
  logic [2:0]  w_cap_k;
  logic [15:0] w_next_addr;
  logic [15:0] w_cap_data;

  function automatic logic [3:0] slot_code(input logic [2:0] k, input logic [3:0] line,
                                           input logic [15:0] snap);
    case (k)
      3'd0:    slot_code = line;
      3'd1:    slot_code = 4'd10;
      3'd2:    slot_code = snap[15:12];
      3'd3:    slot_code = snap[11:8];
      3'd4:    slot_code = 4'd11;
      3'd5:    slot_code = snap[7:4];
      3'd6:    slot_code = snap[3:0];
      default: slot_code = 4'd12;
    endcase
  endfunction

  function automatic logic [15:0] glyph_addr(input logic [3:0] code, input logic [7:0] row);
    glyph_addr = 16'(ROM_BASE) + 16'(code) * 16'(GLYPH_STRIDE) + 16'(row);
  endfunction

  function automatic logic slot_blank(input logic [2:0] k, input logic [15:0] snap);
    logic [3:0] d;
    logic       is_digit;
    d          = slot_code(k, 4'd0, snap);
    is_digit   = (k == 3'd2) || (k == 3'd3) || (k == 3'd5) || (k == 3'd6);
    slot_blank = is_digit && (d > 4'd9);
`ifdef LEAD_ZERO_BLANK_EN
    if ((k == 3'd2) && (d == 4'd0)) slot_blank = 1'b1;
`endif
  endfunction

  // Trigger looks one scanline ahead: the fetched row is displayed on DrawY+1.
  always_comb begin
    w_ny        = {1'b0, DrawY} + 11'd1;
    w_off       = w_ny - 11'(TOP_Y);
    w_in_region = (w_ny >= 11'(TOP_Y)) && (w_ny < 11'(TOP_Y + NUM_LINES * GLYPH_H));
    w_trig      = (DrawX == 10'(TRIG_X)) && w_in_region;
    w_line      = 4'(w_off / 11'(GLYPH_H));
    w_row       = 8'(w_off % 11'(GLYPH_H));
  end

  // Capture index trails the issue counter by one; in DRAIN the counter has wrapped to 0, giving slot 7.
  always_comb begin
    w_next_k    = r_cnt + 3'd1;
    w_cap_k     = r_cnt - 3'd1;
    w_next_addr = glyph_addr(slot_code(w_next_k, r_line, r_snap), r_row);
    w_cap_data  = slot_blank(w_cap_k, r_snap) ? 16'h0000 : rom_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_line    <= 4'd0;
      r_row     <= 8'd0;
      r_snap    <= 16'h0000;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      rom_addr  <= 16'h0000;
      char_row  <= '0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (DrawX == 10'd0) begin
        if (r_pending) begin
          char_row  <= r_shadow;
          row_valid <= 1'b1;
          r_pending <= 1'b0;
        end else begin
          row_valid <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state  <= S_ISSUE;
            r_cnt    <= 3'd0;
            r_line   <= w_line;
            r_row    <= w_row;
            r_snap   <= floatingpoint[w_line];
            busy     <= 1'b1;
            rom_addr <= glyph_addr(w_line, w_row);
          end
        end
        S_ISSUE: begin
          if (r_cnt != 3'd0) r_shadow[w_cap_k] <= w_cap_data;
          if (r_cnt == 3'd7) r_state <= S_DRAIN;
          else rom_addr <= w_next_addr;
          r_cnt <= r_cnt + 3'd1;
        end
        S_DRAIN: begin
          r_shadow[7] <= w_cap_data;
          busy        <= 1'b0;
          r_state     <= S_COMMIT;
        end
        default: begin
          r_pending <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase

      if (w_trig && (r_state != S_IDLE)) overrun <= 1'b1;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_glyph_prefetch_ctrl.sv
// Directed bench for glyph_prefetch_ctrl: table of score-line fetches plus overrun, out-of-region and reset sequences.
module tb_glyph_prefetch_ctrl;

  logic             Clk;
  logic             Reset;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic [9:0][15:0] floatingpoint;
  logic [15:0]      rom_addr;
  logic [15:0]      rom_q;
  logic [7:0][15:0] char_row;
  logic             row_valid;
  logic             busy;
  logic             overrun;
  logic [1:0]       o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [9:0]       y;
    logic [3:0]       line;
    logic [15:0]      fp;
    logic [7:0][15:0] addr;
    logic [7:0]       blank;
  } vec_t;

  vec_t             vecs[5];
  logic [7:0][15:0] last_exp;

  glyph_prefetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .floatingpoint(floatingpoint), .rom_addr(rom_addr), .rom_q(rom_q),
    .char_row(char_row), .row_valid(row_valid), .busy(busy), .overrun(overrun),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous ROM model: data one cycle after the address
  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    rom_fn = {a[7:0], ~a[7:0]};
  endfunction

  always @(posedge Clk) rom_q <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] y, input logic [3:0] line, input logic [15:0] fp,
                              input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                              input logic [15:0] a3, input logic [15:0] a4, input logic [15:0] a5,
                              input logic [15:0] a6, input logic [15:0] a7, input logic [7:0] blank);
    vec_t v;
    v.y = y; v.line = line; v.fp = fp; v.blank = blank;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
    v.addr[4] = a4; v.addr[5] = a5; v.addr[6] = a6; v.addr[7] = a7;
    return v;
  endfunction

  // One full fetch; optional second trigger lands 3 cycles after the first
  task automatic run_fetch(input vec_t v, input bit second_trig, input logic exp_ovr);
    @(negedge Clk);
    DrawX = 10'd640; DrawY = v.y; floatingpoint[v.line] = v.fp;
    @(negedge Clk);
    DrawX = 10'd641;
    check("busy_after_trigger", 32'(busy), 32'd1);
    check("addr_slot0", 32'(rom_addr), 32'(v.addr[0]));
    floatingpoint[v.line] = ~v.fp;
    for (int k = 1; k < 8; k++) begin
      @(negedge Clk);
      check($sformatf("addr_slot%0d", k), 32'(rom_addr), 32'(v.addr[k]));
      if (second_trig && k == 2) DrawX = 10'd640;
      if (k == 3) DrawX = 10'd641;
    end
    @(negedge Clk);
    check("busy_in_drain", 32'(busy), 32'd1);
    @(negedge Clk);
    check("busy_in_commit", 32'(busy), 32'd0);
    @(negedge Clk);
    DrawX = 10'd0;
    @(negedge Clk);
    DrawX = 10'd1;
    check("row_valid", 32'(row_valid), 32'd1);
    for (int k = 0; k < 8; k++) begin
      last_exp[k] = v.blank[k] ? 16'h0000 : rom_fn(v.addr[k]);
      check($sformatf("char_row_slot%0d", k), 32'(char_row[k]), 32'(last_exp[k]));
    end
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  // Trigger outside the text region: nothing fetched, row_valid drops at DrawX == 0
  task automatic no_trigger(input logic [9:0] y);
    logic [15:0] a_before;
    @(negedge Clk);
    a_before = rom_addr;
    DrawX = 10'd640; DrawY = y;
    @(negedge Clk);
    DrawX = 10'd641;
    check("outside_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge Clk);
    check("outside_rom_addr_held", 32'(rom_addr), 32'(a_before));
    DrawX = 10'd0;
    @(negedge Clk);
    DrawX = 10'd1;
    check("outside_row_valid", 32'(row_valid), 32'd0);
    check("outside_char_row_held0", 32'(char_row[0]), 32'(last_exp[0]));
    check("outside_char_row_held7", 32'(char_row[7]), 32'(last_exp[7]));
  endtask

  initial begin
    vecs[0] = mk(10'd163, 4'd0, 16'h0975, 16'd0, 16'd160, 16'd0, 16'd144,
                 16'd176, 16'd112, 16'd80, 16'd192, LZ ? 8'h04 : 8'h00);
    vecs[1] = mk(10'd192, 4'd1, 16'h1234, 16'd30, 16'd174, 16'd30, 16'd46,
                 16'd190, 16'd62, 16'd78, 16'd206, 8'h00);
    vecs[2] = mk(10'd193, 4'd2, 16'hA123, 16'd32, 16'd160, 16'd160, 16'd16,
                 16'd176, 16'd32, 16'd48, 16'd192, 8'h04);
    vecs[3] = mk(10'd193, 4'd2, 16'h0123, 16'd32, 16'd160, 16'd0, 16'd16,
                 16'd176, 16'd32, 16'd48, 16'd192, LZ ? 8'h04 : 8'h00);
    vecs[4] = mk(10'd312, 4'd9, 16'h9F00, 16'd158, 16'd174, 16'd158, 16'd254,
                 16'd190, 16'd14, 16'd14, 16'd206, 8'h08);

    Reset = 1'b0; DrawX = 10'd1; DrawY = 10'd0; floatingpoint = '0; last_exp = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_row_valid", 32'(row_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_char_row0", 32'(char_row[0]), 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'd0);

    for (int i = 0; i < 5; i++) run_fetch(vecs[i], 1'b0, 1'b0);

    run_fetch(vecs[0], 1'b1, 1'b1);
    no_trigger(10'd313);
    no_trigger(10'd162);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset for two cycles in the middle of ISSUE
    @(negedge Clk);
    DrawX = 10'd640; DrawY = vecs[1].y; floatingpoint[1] = vecs[1].fp;
    @(negedge Clk);
    DrawX = 10'd641;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_row_valid", 32'(row_valid), 32'd0);
    check("midreset_overrun", 32'(overrun), 32'd0);
    for (int k = 0; k < 8; k++)
      check($sformatf("midreset_char_row%0d", k), 32'(char_row[k]), 32'd0);
    repeat (10) @(negedge Clk);
    DrawX = 10'd0;
    @(negedge Clk);
    DrawX = 10'd1;
    check("midreset_no_partial_valid", 32'(row_valid), 32'd0);
    check("midreset_no_partial_data", 32'(char_row[0]), 32'd0);

    run_fetch(vecs[0], 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
